traffic_light_intersection: RTL and testbench
=============================================

Name: traffic_light_intersection

Overview:
Two-approach intersection controller (main road and side road) and the parametrised successor of the single-signal controller. Adds per-phase cycle counts as parameters, an all-red clearance interval between conflicting greens, a latched pedestrian walk request, and a night/fault flashing mode. Drives lamp drivers directly from registered outputs on the 50 MHz board clock.

Parameters:
CNT_W, 32, phase counter width; must hold the largest cycle count below.
GREEN_CYCLES, 500_000_000, length of the main and side green phases in cycles (10 s).
YELLOW_CYCLES, 250_000_000, length of each yellow phase in cycles (5 s).
ALL_RED_CYCLES, 50_000_000, length of the all-red clearance in cycles (1 s).
FLASH_HALF_CYCLES, 25_000_000, half-period of flash mode in cycles (1 Hz blink).
All counts are at least 1. Values outside that range are illegal; simulation asserts on them.

Ports:
clk  in  1  50 MHz clock
rst_n  in  1  asynchronous active-low reset
ped_req  in  1  pedestrian button, synchronous, any pulse width ≥1 cycle
flash_mode  in  1  level; 1 = flashing mode
main_red/main_yellow/main_green  out  1 each  main-road lamps
side_red/side_yellow/side_green  out  1 each  side-road lamps
walk  out  1  pedestrian walk lamp (crossing the main road)
phase  out  3  current state encoding, for debug and test

Behaviour:
- Clock and reset: one clock `clk`; reset is asynchronous and active-low on `rst_n`.
- Reset values:
  - state = ALL_RED_2, counter = 0, ped_pending = 0, flash_on = 1.
  - main_red = side_red = 1; all other lamps and walk = 0.
- State sequence and phase lengths:
  - MAIN_GREEN (G) → MAIN_YELLOW (Y) → ALL_RED_1 (R) → SIDE_GREEN (G) → SIDE_YELLOW (Y) → ALL_RED_2 (R) → MAIN_GREEN.
  - Each phase lasts exactly its parameter count of cycles. Counter runs 0..N-1; the transition fires on the cycle where counter == N-1.
  - Counter clears to 0 on every state change. After reset release, ALL_RED_2 lasts ALL_RED_CYCLES.
- Lamp decode:
  - Non-flash states: exactly one lamp per approach is lit.
  - Green or yellow on one approach forces red on the other. Both approaches are never green or yellow together.
- Output timing:
  - Lamp outputs and phase are registered from next-state decode, so they change on the same edge as state. There is no one-cycle lag.
- Pedestrian request:
  - ped_req sets ped_pending.
  - On entry to SIDE_GREEN, walk_active is set to ped_pending OR ped_req, and ped_pending clears.
  - walk = walk_active throughout SIDE_GREEN; walk = 0 in every other state.
  - A ped_req during SIDE_GREEN (after the entry cycle) stays pending for the next cycle of the sequence.
  - A ped_req on the entry cycle is served in the current phase.
- Flash mode:
  - flash_mode = 1 in any state → next edge enters FLASH, counter = 0, flash_on = 1, ped_pending and walk cleared.
  - In FLASH: main_yellow = flash_on, side_red = flash_on, all other lamps = 0. flash_on toggles when counter == FLASH_HALF_CYCLES-1; counter then wraps to 0.
  - flash_mode = 0 while in FLASH → next edge enters ALL_RED_2 with counter = 0 (safe restart through clearance).
  - flash_mode has priority over a same-cycle phase timeout.
- Illegal state encoding → next edge goes to ALL_RED_2, with both reds lit.
- Asynchronous reset mid-phase immediately forces the reset values, without waiting for a clock edge.

Decomposition:
- Package traffic_light_pkg holds:
  - the state encoding (3-bit enum: MAIN_GREEN, MAIN_YELLOW, ALL_RED_1, SIDE_GREEN, SIDE_YELLOW, ALL_RED_2, FLASH);
  - the 3-bit lamp-bundle constants LAMP_RED, LAMP_YELLOW, LAMP_GREEN, LAMP_OFF.
- Sub-module tl_phase_timer (CNT_W; inputs clear and limit; outputs done and count) is used for both phase timing and the flash half-period.

Test Plan:
Use GREEN=8, YELLOW=3, ALL_RED=2, FLASH_HALF=4 for all scenarios below.
- Reset release, no inputs → ALL_RED_2 for 2 cycles, then main_green for 8, main_yellow for 3, all-red for 2, side_green for 8, side_yellow for 3, all-red for 2. Period is 26 cycles and repeats.
- ped_req 1-cycle pulse during MAIN_GREEN cycle 2 → walk = 1 for exactly the 8 SIDE_GREEN cycles; walk = 0 in the following period.
- ped_req on the SIDE_GREEN entry cycle → walk lit in that phase. A second pulse at SIDE_GREEN cycle 4 → walk lit again in the next SIDE_GREEN.
- flash_mode raised at MAIN_GREEN cycle 5 → next edge: main_yellow = 1, side_red = 1, toggling every 4 cycles. Drop flash_mode → 2-cycle all-red, then main_green.
- Assert rst_n = 0 mid-SIDE_YELLOW without a clock edge → both reds lit, walk = 0 immediately. Release → 2-cycle all-red, then main_green.
- Continuous check: no cycle has (main_green|main_yellow) & (side_green|side_yellow). Outside FLASH, each approach has exactly one lamp lit.

Source files
------------

// File: rtl/traffic_light_intersection_pkg.sv
// Shared encodings for the two-approach intersection controller:
// state codes, lamp bundles and the state-to-lamp decode.
package traffic_light_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_1   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_2   = 3'd5,
    FLASH       = 3'd6
  } tl_state_e;

  // Lamp bundle bit order is {red, yellow, green}.
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  typedef struct packed {
    logic [2:0] main_lamp;
    logic [2:0] side_lamp;
  } tl_lamps_t;

  // Any state that does not give an approach right of way shows red on it,
  // so unknown codes fall back to both reds.
  function automatic tl_lamps_t lamp_decode(tl_state_e st, logic flash_on);
    tl_lamps_t l;
    l.main_lamp = LAMP_RED;
    l.side_lamp = LAMP_RED;
    case (st)
      MAIN_GREEN:  l.main_lamp = LAMP_GREEN;
      MAIN_YELLOW: l.main_lamp = LAMP_YELLOW;
      SIDE_GREEN:  l.side_lamp = LAMP_GREEN;
      SIDE_YELLOW: l.side_lamp = LAMP_YELLOW;
      FLASH: begin
        l.main_lamp = flash_on ? LAMP_YELLOW : LAMP_OFF;
        l.side_lamp = flash_on ? LAMP_RED : LAMP_OFF;
      end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_light_intersection_if.sv
// Request inputs and lamp outputs of the intersection controller.
// master = the side driving requests and watching lamps; slave = controller.
interface traffic_light_intersection_if;
  logic       ped_req;
  logic       flash_mode;
  logic       main_red;
  logic       main_yellow;
  logic       main_green;
  logic       side_red;
  logic       side_yellow;
  logic       side_green;
  logic       walk;
  logic [2:0] phase;

  modport master (
    output ped_req, flash_mode,
    input  main_red, main_yellow, main_green,
    input  side_red, side_yellow, side_green, walk, phase
  );

  modport slave (
    input  ped_req, flash_mode,
    output main_red, main_yellow, main_green,
    output side_red, side_yellow, side_green, walk, phase
  );
endinterface

// File: rtl/traffic_light_intersection_timer.sv
// Up-counting phase timer: counts 0..limit-1, flags the last count and
// wraps to 0 there, or restarts whenever the owner clears it.
module tl_phase_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  assign done  = (r_count == limit - CNT_W'(1));
  assign count = r_count;

  // Advance the count; restart on clear or after the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_count <= '0;
    else if (clear || done)  r_count <= '0;
    else                     r_count <= r_count + CNT_W'(1);
  end

endmodule

// File: rtl/traffic_light_intersection.sv
// Main/side road intersection controller with all-red clearance, latched
// pedestrian request and flashing mode. Lamps and phase are registered from
// the next-state decode so they switch on the same edge as the state.
//
// state       | meaning
// MAIN_GREEN  | main road go, side red
// MAIN_YELLOW | main road clearing, side red
// ALL_RED_1   | clearance before side green
// SIDE_GREEN  | side road go, walk lit if a request was latched
// SIDE_YELLOW | side road clearing, main red
// ALL_RED_2   | clearance before main green; reset and flash-exit state
// FLASH       | main yellow / side red blinking together
module traffic_light_intersection
  import traffic_light_pkg::*;
#(
  parameter int          CNT_W             = 32,
  parameter int unsigned GREEN_CYCLES      = 500_000_000,
  parameter int unsigned YELLOW_CYCLES     = 250_000_000,
  parameter int unsigned ALL_RED_CYCLES    = 50_000_000,
  parameter int unsigned FLASH_HALF_CYCLES = 25_000_000
) (
  input logic                          clk,
  input logic                          rst_n,
  traffic_light_intersection_if.slave  tl
);

  if (GREEN_CYCLES == 0 || YELLOW_CYCLES == 0 || ALL_RED_CYCLES == 0 ||
      FLASH_HALF_CYCLES == 0) begin : g_bad_count
    $error("traffic_light_intersection: every cycle count must be at least 1");
  end
  if ((64'(GREEN_CYCLES) >> CNT_W) != 0 || (64'(YELLOW_CYCLES) >> CNT_W) != 0 ||
      (64'(ALL_RED_CYCLES) >> CNT_W) != 0 ||
      (64'(FLASH_HALF_CYCLES) >> CNT_W) != 0) begin : g_bad_width
    $error("traffic_light_intersection: CNT_W too narrow for a cycle count");
  end

  tl_state_e        r_state, w_nxt;
  logic             r_flash_on, w_flash_on_nxt;
  logic             r_ped_pending, w_ped_pending_nxt;
  logic             r_walk, w_walk_nxt;
  tl_lamps_t        r_lamps, w_lamps_nxt;
  logic             w_clear, w_done;
  logic [CNT_W-1:0] w_limit, w_count;

  // One timer serves every phase; in FLASH it times the blink half-period.
  tl_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_clear),
    .limit (w_limit),
    .done  (w_done),
    .count (w_count)
  );

  // Select the length of the current phase.
  always_comb begin
    w_limit = CNT_W'(ALL_RED_CYCLES);
    case (r_state)
      MAIN_GREEN, SIDE_GREEN:   w_limit = CNT_W'(GREEN_CYCLES);
      MAIN_YELLOW, SIDE_YELLOW: w_limit = CNT_W'(YELLOW_CYCLES);
      FLASH:                    w_limit = CNT_W'(FLASH_HALF_CYCLES);
      default: ;
    endcase
  end

  // Next state, pedestrian bookkeeping and lamp decode of the next state.
  always_comb begin
    w_nxt             = r_state;
    w_flash_on_nxt    = r_flash_on;
    w_ped_pending_nxt = r_ped_pending | tl.ped_req;
    w_walk_nxt        = 1'b0;
    if (tl.flash_mode) begin
      w_nxt = FLASH;
    end else begin
      case (r_state)
        MAIN_GREEN:  if (w_done) w_nxt = MAIN_YELLOW;
        MAIN_YELLOW: if (w_done) w_nxt = ALL_RED_1;
        ALL_RED_1:   if (w_done) w_nxt = SIDE_GREEN;
        SIDE_GREEN:  if (w_done) w_nxt = SIDE_YELLOW;
        SIDE_YELLOW: if (w_done) w_nxt = ALL_RED_2;
        ALL_RED_2:   if (w_done) w_nxt = MAIN_GREEN;
        default:     w_nxt = ALL_RED_2;
      endcase
    end
    if (w_nxt == FLASH) begin
      w_ped_pending_nxt = 1'b0;
      if (r_state != FLASH) w_flash_on_nxt = 1'b1;
      else if (w_done)      w_flash_on_nxt = ~r_flash_on;
    end else if (w_nxt == SIDE_GREEN) begin
      // A request arriving on the edge into SIDE_GREEN is served immediately.
      if (r_state != SIDE_GREEN) begin
        w_walk_nxt        = r_ped_pending | tl.ped_req;
        w_ped_pending_nxt = 1'b0;
      end else begin
        w_walk_nxt = r_walk;
      end
    end
    w_lamps_nxt = lamp_decode(w_nxt, w_flash_on_nxt);
    w_clear     = (w_nxt != r_state);
  end

  // State and registered lamp outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ALL_RED_2;
      r_flash_on    <= 1'b1;
      r_ped_pending <= 1'b0;
      r_walk        <= 1'b0;
      r_lamps       <= '{main_lamp: LAMP_RED, side_lamp: LAMP_RED};
    end else begin
      r_state       <= w_nxt;
      r_flash_on    <= w_flash_on_nxt;
      r_ped_pending <= w_ped_pending_nxt;
      r_walk        <= w_walk_nxt;
      r_lamps       <= w_lamps_nxt;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) w_count < w_limit);

  assign tl.main_red    = r_lamps.main_lamp[2];
  assign tl.main_yellow = r_lamps.main_lamp[1];
  assign tl.main_green  = r_lamps.main_lamp[0];
  assign tl.side_red    = r_lamps.side_lamp[2];
  assign tl.side_yellow = r_lamps.side_lamp[1];
  assign tl.side_green  = r_lamps.side_lamp[0];
  assign tl.walk        = r_walk;
  assign tl.phase       = r_state;

endmodule

// File: tb/tb_traffic_light_intersection.sv
// Directed bench for traffic_light_intersection with short phase counts
// (green 8, yellow 3, all-red 2, flash half-period 4).
module tb_traffic_light_intersection;
  import traffic_light_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic mon_en = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   t      = 0;
  int   t_base = 0;

  traffic_light_intersection_if tl_if ();

  traffic_light_intersection #(
    .CNT_W             (8),
    .GREEN_CYCLES      (8),
    .YELLOW_CYCLES     (3),
    .ALL_RED_CYCLES    (2),
    .FLASH_HALF_CYCLES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tl    (tl_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, act, exp, t);
    end
  endtask

  // Phase expected at offset p (0..25) of the 26-cycle period after clearance.
  function automatic logic [2:0] exp_phase(input int p);
    if (p < 2)  return ALL_RED_2;
    if (p < 10) return MAIN_GREEN;
    if (p < 13) return MAIN_YELLOW;
    if (p < 15) return ALL_RED_1;
    if (p < 23) return SIDE_GREEN;
    return SIDE_YELLOW;
  endfunction

  // {main r,y,g, side r,y,g}
  function automatic logic [5:0] exp_lamps(input logic [2:0] ph, input logic fo);
    case (ph)
      3'd0:    return 6'b001_100;
      3'd1:    return 6'b010_100;
      3'd3:    return 6'b100_001;
      3'd4:    return 6'b100_010;
      3'd6:    return fo ? 6'b010_100 : 6'b000_000;
      default: return 6'b100_100;
    endcase
  endfunction

  function automatic logic [5:0] obs_lamps();
    return {tl_if.main_red, tl_if.main_yellow, tl_if.main_green,
            tl_if.side_red, tl_if.side_yellow, tl_if.side_green};
  endfunction

  task automatic check_cycle(input logic [2:0] ph, input logic fo, input logic wk);
    chk("phase", 32'(tl_if.phase), 32'(ph));
    chk("lamps", 32'(obs_lamps()), 32'(exp_lamps(ph, fo)));
    chk("walk", 32'(tl_if.walk), 32'(wk));
  endtask

  // Safety: no conflicting right of way; one lamp per approach outside FLASH.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("no_conflict",
          32'((tl_if.main_green | tl_if.main_yellow) & (tl_if.side_green | tl_if.side_yellow)), 32'd0);
      if (tl_if.phase != FLASH) begin
        chk("main_one_lamp", 32'($countones({tl_if.main_red, tl_if.main_yellow, tl_if.main_green})), 32'd1);
        chk("side_one_lamp", 32'($countones({tl_if.side_red, tl_if.side_yellow, tl_if.side_green})), 32'd1);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p;
    int k;
    tl_if.ped_req    = 1'b0;
    tl_if.flash_mode = 1'b0;
    #1 rst_n = 1'b0;
    #3;
    check_cycle(ALL_RED_2, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    t = 0;
    t_base = 0;
    check_cycle(ALL_RED_2, 1'b1, 1'b0);

    // Free run, request in MAIN_GREEN cycle 2, request on the edge into
    // SIDE_GREEN, and a request at SIDE_GREEN cycle 4 served one period later.
    while (t < 155) begin
      tl_if.ped_req = (t == 56 || t == 118 || t == 123);
      @(negedge clk); t++;
      p = t % 26;
      k = t / 26;
      check_cycle(exp_phase(p), 1'b1, (p >= 15 && p <= 22 && (k == 2 || k == 4 || k == 5)));
    end
    tl_if.ped_req = 1'b0;

    // Flash raised at MAIN_GREEN cycle 5; a request during flash is dropped.
    while (t < 163) begin
      @(negedge clk); t++;
      check_cycle(exp_phase(t % 26), 1'b1, 1'b0);
    end
    tl_if.flash_mode = 1'b1;
    while (t < 175) begin
      tl_if.ped_req = (t == 168);
      @(negedge clk); t++;
      check_cycle(FLASH, (((t - 164) / 4) % 2) == 0, 1'b0);
    end
    tl_if.ped_req    = 1'b0;
    tl_if.flash_mode = 1'b0;
    t_base = 176;

    // Restart through clearance; a request in SIDE_GREEN stays pending.
    while (t < 200) begin
      tl_if.ped_req = (t == 195);
      @(negedge clk); t++;
      check_cycle(exp_phase((t - t_base) % 26), 1'b1, 1'b0);
    end
    tl_if.ped_req = 1'b0;

    // Asynchronous reset mid-SIDE_YELLOW, between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check_cycle(ALL_RED_2, 1'b1, 1'b0);
    @(negedge clk);
    check_cycle(ALL_RED_2, 1'b1, 1'b0);
    rst_n = 1'b1;
    t = 0;
    t_base = 0;
    check_cycle(ALL_RED_2, 1'b1, 1'b0);
    // The pending request was discarded by reset: no walk in this period.
    while (t < 30) begin
      @(negedge clk); t++;
      check_cycle(exp_phase(t % 26), 1'b1, 1'b0);
    end

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
